// File: rtl/data_mem_pkg.sv
// Shared types for the data-memory arbiter: access size encoding, arbiter
// states and the bundled memory request steered onto the memory port.
package data_mem_pkg;

  localparam int unsigned MEM_DW = 32;

  typedef enum logic [1:0] {
    MEM_RD   = 2'b00,
    MEM_WORD = 2'b01,
    MEM_HALF = 2'b10,
    MEM_BYTE = 2'b11
  } mem_we_t;

  typedef enum logic [1:0] {
    ST_CPU_PRI   = 2'b00,
    ST_DMA_FORCE = 2'b01,
    ST_DMA_BURST = 2'b10
  } arb_state_t;

  typedef struct packed {
    mem_we_t           we;
    logic [MEM_DW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter between the CPU load/store path and a
// DMA/loader port. The grant is combinational from requests and state, so a
// granted access completes in the cycle it is acked. CPU has priority; DMA is
// protected by a starvation counter and may hold the port for a bounded burst.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DW,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned BURST_MAX  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic [1:0]            cpu_we_i,
  input  logic [DATA_WIDTH-1:0] cpu_a_i,
  input  logic [DATA_WIDTH-1:0] cpu_wd_i,
  output logic                  cpu_ack_o,
  output logic [DATA_WIDTH-1:0] cpu_rd_o,
  input  logic                  dma_req_i,
  input  logic                  dma_lock_i,
  input  logic [1:0]            dma_we_i,
  input  logic [DATA_WIDTH-1:0] dma_a_i,
  input  logic [DATA_WIDTH-1:0] dma_wd_i,
  output logic                  dma_ack_o,
  output logic [DATA_WIDTH-1:0] dma_rd_o,
  output logic [1:0]            mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_a_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);
  // A one-beat limit means a lock can never extend past the first beat.
  localparam bit BURST_ALLOWED = (BURST_MAX > 1);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          cpu_ack, dma_ack;
  mem_req_t      win;

  // Grant selection and next-state/counter computation.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d  = state_q;
    starve_d = starve_q;
    burst_d  = burst_q;
    cpu_ack  = 1'b0;
    dma_ack  = 1'b0;

    // Reset suppresses every grant so nothing reaches the memory.
    if (!rst) begin
      unique case (state_q)
        ST_CPU_PRI: begin
          if (cpu_req_i)      cpu_ack = 1'b1;
          else if (dma_req_i) dma_ack = 1'b1;
        end
        ST_DMA_FORCE, ST_DMA_BURST: begin
          if (dma_req_i)      dma_ack = 1'b1;
          else if (cpu_req_i) cpu_ack = 1'b1;
        end
        default: ;
      endcase
    end

    unique case (state_q)
      ST_CPU_PRI: begin
        if (dma_ack) begin
          starve_d = '0;
          if (dma_lock_i && BURST_ALLOWED) begin
            state_d = ST_DMA_BURST;
            burst_d = BW'(1);
          end
        end else if (dma_req_i) begin
          if (starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
          if (starve_d == STARVE_LIM) state_d = ST_DMA_FORCE;
        end
      end
      ST_DMA_FORCE: begin
        // The owed grant is consumed, or forfeited if DMA withdrew.
        starve_d = '0;
        if (dma_ack && dma_lock_i && BURST_ALLOWED) begin
          state_d = ST_DMA_BURST;
          burst_d = BW'(1);
        end else begin
          state_d = ST_CPU_PRI;
        end
      end
      ST_DMA_BURST: begin
        if (dma_ack) begin
          starve_d = '0;
          if (burst_q != BURST_LIM) burst_d = burst_q + BW'(1);
          if (!dma_lock_i || burst_d == BURST_LIM) begin
            state_d = ST_CPU_PRI;
            burst_d = '0;
          end
        end else begin
          state_d = ST_CPU_PRI;
          burst_d = '0;
        end
      end
      default: begin
        state_d  = ST_CPU_PRI;
        starve_d = '0;
        burst_d  = '0;
      end
    endcase
  end

  // Arbiter state and counters; synchronous reset drops any burst in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      state_q  <= ST_CPU_PRI;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  // Steer the winner's request onto the memory; an idle port is all zeros.
  always_comb begin
    win = '0;
    if (cpu_ack) begin
      win = '{we: mem_we_t'(cpu_we_i), addr: cpu_a_i, wdata: cpu_wd_i};
    end else if (dma_ack) begin
      win = '{we: mem_we_t'(dma_we_i), addr: dma_a_i, wdata: dma_wd_i};
    end
  end

  assign mem_we_o  = win.we;
  assign mem_a_o   = win.addr;
  assign mem_wd_o  = win.wdata;
  assign cpu_ack_o = cpu_ack;
  assign dma_ack_o = dma_ack;
  assign cpu_rd_o  = cpu_ack ? mem_rd_i : '0;
  assign dma_rd_o  = dma_ack ? mem_rd_i : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a byte-wide memory driven by the DUT's memory
// port, a directed sequence for the named scenarios, then random traffic
// checked against a behavioural model of the arbitration rules.
module tb_data_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int BURST_MAX  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, dma_req, dma_lock;
  logic [1:0]  cpu_we, dma_we, mem_we;
  logic [31:0] cpu_a, cpu_wd, dma_a, dma_wd;
  logic        cpu_ack, dma_ack;
  logic [31:0] cpu_rd, dma_rd, mem_a, mem_wd, mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: consecutive denied DMA requests, a pending owed grant and
  // the number of beats in the current locked run (0 = no run).
  int         denied;
  bit         owed;
  int         beats;
  logic [7:0] ref_mem [256];

  logic        last_cpu_ack, last_dma_ack;
  logic [1:0]  last_mem_we;
  logic [31:0] last_mem_a, last_cpu_rd;
  int          dma_count;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DATA_WIDTH(32),
    .STARVE_MAX(STARVE_MAX),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req_i (cpu_req),
    .cpu_we_i  (cpu_we),
    .cpu_a_i   (cpu_a),
    .cpu_wd_i  (cpu_wd),
    .cpu_ack_o (cpu_ack),
    .cpu_rd_o  (cpu_rd),
    .dma_req_i (dma_req),
    .dma_lock_i(dma_lock),
    .dma_we_i  (dma_we),
    .dma_a_i   (dma_a),
    .dma_wd_i  (dma_wd),
    .dma_ack_o (dma_ack),
    .dma_rd_o  (dma_rd),
    .mem_we_o  (mem_we),
    .mem_a_o   (mem_a),
    .mem_wd_o  (mem_wd),
    .mem_rd_i  (mem_rd)
  );

  // Data memory: 256 bytes mirrored by the low address byte, little endian,
  // combinational read, write at posedge, cleared by reset.
  logic [7:0] mem_bytes [256];
  logic [7:0] ia0, ia1, ia2, ia3;
  assign ia0    = mem_a[7:0];
  assign ia1    = ia0 + 8'd1;
  assign ia2    = ia0 + 8'd2;
  assign ia3    = ia0 + 8'd3;
  assign mem_rd = {mem_bytes[ia3], mem_bytes[ia2], mem_bytes[ia1], mem_bytes[ia0]};

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_bytes[i] <= 8'h00;
    end else begin
      case (mem_we)
        2'b01: begin
          mem_bytes[ia0] <= mem_wd[7:0];   mem_bytes[ia1] <= mem_wd[15:8];
          mem_bytes[ia2] <= mem_wd[23:16]; mem_bytes[ia3] <= mem_wd[31:24];
        end
        2'b10: begin
          mem_bytes[ia0] <= mem_wd[7:0];   mem_bytes[ia1] <= mem_wd[15:8];
        end
        2'b11: mem_bytes[ia0] <= mem_wd[7:0];
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {ref_mem[8'(b + 8'd3)], ref_mem[8'(b + 8'd2)],
            ref_mem[8'(b + 8'd1)], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [1:0] we, input logic [31:0] a,
                           input logic [31:0] wd);
    int nbytes;
    logic [7:0] b;
    b = a[7:0];
    nbytes = (we == 2'b01) ? 4 : (we == 2'b10) ? 2 : (we == 2'b11) ? 1 : 0;
    for (int k = 0; k < nbytes; k++) ref_mem[8'(b + 8'(k))] = wd[8*k +: 8];
  endtask

  // One clock cycle: predict the winner from the rules, compare all outputs,
  // then advance the model and the shadow memory across the edge.
  task automatic cycle();
    int          win;  // 0 none, 1 cpu, 2 dma
    logic [1:0]  e_we;
    logic [31:0] e_a, e_wd;
    #1;
    if (rst)                                   win = 0;
    else if ((beats > 0 || owed) && dma_req)   win = 2;
    else if (cpu_req)                          win = 1;
    else if (dma_req)                          win = 2;
    else                                       win = 0;
    e_we = (win == 1) ? cpu_we : (win == 2) ? dma_we : 2'b00;
    e_a  = (win == 1) ? cpu_a  : (win == 2) ? dma_a  : 32'h0;
    e_wd = (win == 1) ? cpu_wd : (win == 2) ? dma_wd : 32'h0;
    check("cpu_ack", 32'(cpu_ack), 32'(win == 1));
    check("dma_ack", 32'(dma_ack), 32'(win == 2));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_a", mem_a, e_a);
    check("mem_wd", mem_wd, e_wd);
    check("cpu_rd", cpu_rd, (win == 1) ? ref_read(cpu_a) : 32'h0);
    check("dma_rd", dma_rd, (win == 2) ? ref_read(dma_a) : 32'h0);
    last_cpu_ack = cpu_ack;
    last_dma_ack = dma_ack;
    last_mem_we  = mem_we;
    last_mem_a   = mem_a;
    last_cpu_rd  = cpu_rd;
    @(posedge clk);
    if (rst) begin
      denied = 0; owed = 0; beats = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    end else begin
      if (win != 0) ref_write(e_we, e_a, e_wd);
      if (win == 2) begin
        denied = 0;
        owed   = 0;
        if (beats > 0) begin
          beats++;
          if (!dma_lock || beats >= BURST_MAX) beats = 0;
        end else if (dma_lock && BURST_MAX > 1) begin
          beats = 1;
        end
      end else begin
        beats = 0;
        if (owed) begin
          owed = 0; denied = 0;
        end else if (dma_req) begin
          denied++;
          if (denied >= STARVE_MAX) begin
            denied = STARVE_MAX;
            owed   = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 2'b00; cpu_a = 32'h0; cpu_wd = 32'h0;
    dma_req = 0; dma_lock = 0; dma_we = 2'b00; dma_a = 32'h0; dma_wd = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    denied = 0; owed = 0; beats = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    idle_inputs();
    rst = 1;
    cpu_req = 1; dma_req = 1;
    cycle();
    check("rst_no_ack", 32'({last_cpu_ack, last_dma_ack}), 32'h0);
    cycle();
    rst = 0;
    idle_inputs();

    // CPU-only write then read back.
    cpu_req = 1; cpu_we = 2'b01; cpu_a = 32'h0001_0000; cpu_wd = 32'hDEAD_BEEF;
    cycle();
    check("t1_wr_ack", 32'(last_cpu_ack), 32'h1);
    cpu_we = 2'b00; cpu_wd = 32'h0;
    cycle();
    check("t1_rd_data", last_cpu_rd, 32'hDEAD_BEEF);
    check("t1_no_dma", 32'(last_dma_ack), 32'h0);

    // Blocked DMA write while CPU holds the port.
    dma_req = 1; dma_we = 2'b01; dma_a = 32'h0001_0000; dma_wd = 32'h1111_1111;
    cycle();
    check("t4_dma_denied", 32'(last_dma_ack), 32'h0);
    dma_req = 0; dma_we = 2'b00; dma_wd = 32'h0;
    cycle();
    check("t4_mem_intact", last_cpu_rd, 32'hDEAD_BEEF);
    check("t4_mem_byte", 32'(mem_bytes[1]), 32'hBE);

    // Idle port.
    idle_inputs();
    repeat (3) begin
      cycle();
      check("t6_idle_we", 32'(last_mem_we), 32'h0);
      check("t6_idle_a", last_mem_a, 32'h0);
    end

    // Contention: DMA gets every fifth cycle.
    do_reset();
    cpu_req = 1; cpu_a = 32'h0001_0000;
    dma_req = 1; dma_a = 32'h0001_0008;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t2_dma_slot", 32'(last_dma_ack), 32'((i % 5) == 4));
    end

    // Forced grant opening a locked burst capped at BURST_MAX beats.
    do_reset();
    idle_inputs();
    cpu_req = 1; cpu_we = 2'b01; cpu_a = 32'h0001_0004; cpu_wd = 32'h5566_7788;
    cycle();
    cpu_we = 2'b00; cpu_a = 32'h0001_0000; cpu_wd = 32'h0;
    dma_req = 1; dma_lock = 1; dma_we = 2'b11; dma_a = 32'h0001_0004;
    dma_wd = 32'h0000_00AB;
    dma_count = 0;
    for (int i = 0; i < 13; i++) begin
      cycle();
      if (last_dma_ack) dma_count++;
      check("t3_burst_slot", 32'(last_dma_ack), 32'(i >= 4 && i <= 11));
    end
    check("t3_burst_len", 32'(dma_count), 32'(BURST_MAX));
    dma_req = 0; dma_lock = 0; dma_we = 2'b00;
    cpu_a = 32'h0001_0004;
    cycle();
    check("t3_byte_merge", last_cpu_rd, 32'h5566_77AB);
    check("t3_next_byte", 32'(mem_bytes[5]), 32'h77);

    // Reset in the middle of a burst.
    do_reset();
    idle_inputs();
    dma_req = 1; dma_lock = 1; dma_we = 2'b01; dma_a = 32'h0001_0020;
    dma_wd = 32'hCAFE_0000;
    cycle();
    cycle();
    check("t5_burst_beat", 32'(last_dma_ack), 32'h1);
    rst = 1; cpu_req = 1; cpu_we = 2'b01;
    repeat (2) begin
      cycle();
      check("t5_rst_acks", 32'({last_cpu_ack, last_dma_ack}), 32'h0);
      check("t5_rst_we", 32'(last_mem_we), 32'h0);
    end
    rst = 0; cpu_we = 2'b00;
    cycle();
    check("t5_cpu_first", 32'(last_cpu_ack), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      cpu_req  = ($urandom_range(0, 9) < 6);
      dma_req  = ($urandom_range(0, 9) < 6);
      dma_lock = ($urandom_range(0, 1) == 1);
      cpu_we   = 2'($urandom_range(0, 3));
      dma_we   = 2'($urandom_range(0, 3));
      cpu_a    = 32'h0001_0000 | 32'($urandom_range(0, 255));
      dma_a    = 32'h0001_0000 | 32'($urandom_range(0, 255));
      cpu_wd   = $urandom;
      dma_wd   = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
